// File: rtl/c64_bus_arbiter.sv
// Two-phase C64 memory bus arbiter: phase 0 serves the VIC, phase 1 the CPU,
// with a BA warning period before the VIC takes both phases for DMA.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_SHARE   | normal interleave; VIC on phase 0, CPU on phase 1
// ST_WARN    | BA low; CPU writes still complete, CPU reads stall
// ST_STEAL   | VIC owns both phases; CPU stalled
// ST_RELEASE | one forced shared cycle after MAX_STEAL consecutive steals
module c64_bus_arbiter #(
    parameter int MAX_STEAL   = 43,
    parameter int WARN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_ab,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_we,
    output logic [7:0]  cpu_di,
    output logic        cpu_ce,
    output logic        cpu_rdy,
    input  logic [15:0] vic_ab,
    input  logic        vic_req,
    output logic [7:0]  vic_di,
    output logic [15:0] mem_ab,
    output logic [7:0]  mem_do,
    output logic        mem_we,
    input  logic [7:0]  mem_di,
    output logic        phase,
    output logic        ba,
    output logic        aec
);

    typedef enum logic [1:0] {
        ST_SHARE,
        ST_WARN,
        ST_STEAL,
        ST_RELEASE
    } state_t;

    localparam logic [1:0] WARN_LAST  = 2'(WARN_CYCLES - 1);
    localparam logic [5:0] STEAL_LAST = 6'(MAX_STEAL - 1);

    state_t      state_q, state_d;
    logic        phase_q;
    logic [1:0]  warn_cnt_q, warn_cnt_d;
    logic [5:0]  steal_cnt_q, steal_cnt_d;
    logic [7:0]  cpu_di_q, vic_di_q;
    logic        vic_owns;

    // Transitions are only evaluated on the edge that closes phase 1.
    always_comb begin
        state_d     = state_q;
        warn_cnt_d  = warn_cnt_q;
        steal_cnt_d = steal_cnt_q;
        if (phase_q) begin
            case (state_q)
                ST_SHARE: begin
                    if (vic_req) begin
                        state_d    = ST_WARN;
                        warn_cnt_d = '0;
                    end
                end
                ST_WARN: begin
                    if (!vic_req) begin
                        state_d = ST_SHARE;
                    end else if (warn_cnt_q >= WARN_LAST) begin
                        state_d     = ST_STEAL;
                        steal_cnt_d = '0;
                    end else begin
                        warn_cnt_d = warn_cnt_q + 2'd1;
                    end
                end
                ST_STEAL: begin
                    if (!vic_req) begin
                        state_d = ST_SHARE;
                    end else if (steal_cnt_q >= STEAL_LAST) begin
                        state_d = ST_RELEASE;
                    end else begin
                        steal_cnt_d = steal_cnt_q + 6'd1;
                    end
                end
                ST_RELEASE: begin
                    if (vic_req) begin
                        state_d    = ST_WARN;
                        warn_cnt_d = '0;
                    end else begin
                        state_d = ST_SHARE;
                    end
                end
                default: state_d = ST_SHARE;
            endcase
        end
    end

    always_comb begin
        ba      = 1'b1;
        aec     = 1'b1;
        cpu_rdy = 1'b1;
        case (state_q)
            ST_WARN: begin
                ba      = 1'b0;
                cpu_rdy = cpu_we;
            end
            ST_STEAL: begin
                ba      = 1'b0;
                aec     = 1'b0;
                cpu_rdy = 1'b0;
            end
            default: ;
        endcase
    end

    assign vic_owns = !phase_q || !aec;
    assign mem_ab   = vic_owns ? vic_ab : cpu_ab;
    assign mem_do   = cpu_do;
    assign mem_we   = cpu_we & cpu_rdy & phase_q & aec;
    assign cpu_ce   = phase_q & cpu_rdy;
    assign phase    = phase_q;
    assign cpu_di   = cpu_di_q;
    assign vic_di   = vic_di_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q     <= 1'b0;
            state_q     <= ST_SHARE;
            warn_cnt_q  <= '0;
            steal_cnt_q <= '0;
            cpu_di_q    <= '0;
            vic_di_q    <= '0;
        end else begin
            phase_q     <= ~phase_q;
            state_q     <= state_d;
            warn_cnt_q  <= warn_cnt_d;
            steal_cnt_q <= steal_cnt_d;
            // A stalled read leaves cpu_di untouched so the core sees stable data.
            if (phase_q && aec && cpu_rdy && !cpu_we) begin
                cpu_di_q <= mem_di;
            end
            if (vic_owns) begin
                vic_di_q <= mem_di;
            end
        end
    end

endmodule

// File: tb/tb_c64_bus_arbiter.sv
// Bench for c64_bus_arbiter: directed stimulus, a per-tick behavioural model
// based on the length of the current unbroken request run, plus literal pins.
module tb_c64_bus_arbiter;

    localparam int MAX_STEAL   = 43;
    localparam int WARN_CYCLES = 3;
    localparam int PERIOD      = WARN_CYCLES + MAX_STEAL + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_ab;
    logic [7:0]  cpu_do;
    logic        cpu_we;
    logic [7:0]  cpu_di;
    logic        cpu_ce;
    logic        cpu_rdy;
    logic [15:0] vic_ab;
    logic        vic_req;
    logic [7:0]  vic_di;
    logic [15:0] mem_ab;
    logic [7:0]  mem_do;
    logic        mem_we;
    logic [7:0]  mem_di;
    logic        phase;
    logic        ba;
    logic        aec;

    always #5 clk = ~clk;

    c64_bus_arbiter #(
        .MAX_STEAL  (MAX_STEAL),
        .WARN_CYCLES(WARN_CYCLES)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .cpu_ab (cpu_ab),
        .cpu_do (cpu_do),
        .cpu_we (cpu_we),
        .cpu_di (cpu_di),
        .cpu_ce (cpu_ce),
        .cpu_rdy(cpu_rdy),
        .vic_ab (vic_ab),
        .vic_req(vic_req),
        .vic_di (vic_di),
        .mem_ab (mem_ab),
        .mem_do (mem_do),
        .mem_we (mem_we),
        .mem_di (mem_di),
        .phase  (phase),
        .ba     (ba),
        .aec    (aec)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Model: m_run counts consecutive cycle boundaries that sampled vic_req=1.
    // Within a run the pattern is WARN x3, STEAL x43, RELEASE x1, repeating.
    bit         m_phase;
    int         m_run;
    logic [7:0] m_cdi, m_vdi;

    // 0 = shared (SHARE or RELEASE), 1 = warning, 2 = stolen
    function automatic int mode_of(input int run);
        int p;
        if (run == 0) return 0;
        p = (run - 1) % PERIOD;
        if (p < WARN_CYCLES) return 1;
        if (p < WARN_CYCLES + MAX_STEAL) return 2;
        return 0;
    endfunction

    function automatic bit exp_rdy(input int md, input logic we);
        if (md == 0) return 1'b1;
        if (md == 1) return we;
        return 1'b0;
    endfunction

    always @(posedge clk) begin : model_upd
        int md;
        bit rdy;
        bit vo;
        if (reset) begin
            m_phase = 1'b0;
            m_run   = 0;
            m_cdi   = 8'h00;
            m_vdi   = 8'h00;
            chk_en  = 1'b1;
        end else begin
            md  = mode_of(m_run);
            rdy = exp_rdy(md, cpu_we);
            vo  = !m_phase || (md == 2);
            if (!vo && !cpu_we && rdy) m_cdi = mem_di;
            if (vo) m_vdi = mem_di;
            if (m_phase) m_run = vic_req ? m_run + 1 : 0;
            m_phase = !m_phase;
        end
    end

    always @(negedge clk) begin : compare
        int md;
        bit rdy;
        bit vo;
        if (chk_en) begin
            md  = mode_of(m_run);
            rdy = exp_rdy(md, cpu_we);
            vo  = !m_phase || (md == 2);
            chk("m_phase",  32'(phase),   32'(m_phase));
            chk("m_ba",     32'(ba),      32'(md == 0));
            chk("m_aec",    32'(aec),     32'(md != 2));
            chk("m_rdy",    32'(cpu_rdy), 32'(rdy));
            chk("m_ce",     32'(cpu_ce),  32'(m_phase & rdy));
            chk("m_we",     32'(mem_we),  32'(cpu_we & rdy & m_phase & (md != 2)));
            chk("m_ab",     32'(mem_ab),  32'(vo ? vic_ab : cpu_ab));
            chk("m_do",     32'(mem_do),  32'(cpu_do));
            chk("m_cpu_di", 32'(cpu_di),  32'(m_cdi));
            chk("m_vic_di", 32'(vic_di),  32'(m_vdi));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assumes phase 0 on entry; leaves phase 0.
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            mem_di = 8'h11 + 8'(i);
            tick();
            mem_di = 8'h5A ^ 8'(i);
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int s;
        int w;
        reset   = 1'b1;
        vic_req = 1'b0;
        cpu_we  = 1'b0;
        cpu_ab  = 16'hC000;
        cpu_do  = 8'h00;
        vic_ab  = 16'h1000;
        mem_di  = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_phase",  32'(phase),   0);
        chk("rst_ba",     32'(ba),      1);
        chk("rst_aec",    32'(aec),     1);
        chk("rst_rdy",    32'(cpu_rdy), 1);
        chk("rst_ce",     32'(cpu_ce),  0);
        chk("rst_we",     32'(mem_we),  0);
        chk("rst_cpu_di", 32'(cpu_di),  0);
        chk("rst_vic_di", 32'(vic_di),  0);

        run_cycles(1);
        chk("idle_cpu_di", 32'(cpu_di), 32'h5A);
        chk("idle_vic_di", 32'(vic_di), 32'h11);
        run_cycles(3);

        // request pulse that falls before the boundary is never seen
        vic_req = 1'b1; mem_di = 8'h22; tick();
        vic_req = 1'b0; mem_di = 8'h33; tick();
        chk("pulse_ignored_ba", 32'(ba), 1);

        // read takeover
        vic_req = 1'b1;
        tick();
        tick();
        chk("warn_ba",  32'(ba),      0);
        chk("warn_rdy", 32'(cpu_rdy), 0);
        tick();
        chk("warn_ce",  32'(cpu_ce),  0);
        n = 1;
        while (aec === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("aec_delay_ticks", n, 6);
        s = 0;
        while (aec === 1'b0 && s < 200) begin
            s++;
            if (s == 2) chk("steal_ab_p1", 32'(mem_ab), 32'h1000);
            tick();
        end
        chk("steal_ticks", s, 2 * MAX_STEAL);
        chk("rel_ba",   32'(ba),      1);
        chk("rel_rdy",  32'(cpu_rdy), 1);
        tick();
        chk("rel_ce",   32'(cpu_ce),  1);
        tick();
        chk("rewarn_ba", 32'(ba), 0);

        // abort in the second warning cycle
        run_cycles(1);
        vic_req = 1'b0;
        run_cycles(1);
        chk("abort_ba", 32'(ba), 1);
        run_cycles(2);

        // write takeover: writes complete during WARN only
        cpu_we  = 1'b1;
        cpu_ab  = 16'hD020;
        cpu_do  = 8'h0E;
        vic_req = 1'b1;
        run_cycles(1);
        w = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 1) begin
                chk("warn_wr_ab", 32'(mem_ab), 32'hD020);
                chk("warn_wr_do", 32'(mem_do), 32'h0E);
            end
            if (mem_we === 1'b1) w++;
            tick();
        end
        chk("warn_writes", w, WARN_CYCLES);

        // release from STEAL
        vic_req = 1'b0;
        tick();
        tick();
        chk("drop_ba",  32'(ba),      1);
        chk("drop_aec", 32'(aec),     1);
        chk("drop_rdy", 32'(cpu_rdy), 1);
        run_cycles(2);

        // reset while stolen
        cpu_we  = 1'b0;
        cpu_ab  = 16'hC000;
        vic_req = 1'b1;
        run_cycles(6);
        chk("pre_rst_aec",    32'(aec),    0);
        chk("pre_rst_cpu_di", 32'(cpu_di), 32'h5A);
        tick();
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        vic_req = 1'b0;
        chk("mid_rst_phase",  32'(phase),  0);
        chk("mid_rst_ba",     32'(ba),     1);
        chk("mid_rst_aec",    32'(aec),    1);
        chk("mid_rst_cpu_di", 32'(cpu_di), 0);
        chk("mid_rst_vic_di", 32'(vic_di), 0);
        run_cycles(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
